// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with link port, bypass and clear sequencer
module regfile_mp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_RD      = 2,
  parameter int LINK_REG    = 31,
  parameter int LINK_OFFSET = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     link_we,
  input  logic [DATA_W-1:0]        link_pc,
  output logic                     init_busy,
  output logic                     wr_collision
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam logic [DATA_W-1:0] LINK_ADD = DATA_W'(LINK_OFFSET);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic [DATA_W-1:0] link_val;
  logic              link_en;
  logic              gen_en;
  logic              collide;
  logic              gen_commit;

  // Sequencer state, clear pointer and the registered collision flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= ADDR_W'(1);
      wr_collision <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (state_q == S_CLEAR) begin
        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      end
      wr_collision <= collide;
    end
  end

  // Next state: leave CLEAR once the top register has been zeroed
  always_comb begin
    state_d   = state_q;
    init_busy = 1'b1;
    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == LAST_IDX) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        init_busy = 1'b0;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // Write qualification; the link port wins when both target the link register
  always_comb begin
    ready      = (state_q == S_READY);
    link_val   = link_pc + LINK_ADD;
    link_en    = ready && link_we;
    gen_en     = ready && we && (waddr != '0);
    collide    = gen_en && link_en && (waddr == LINK_IDX);
    gen_commit = gen_en && !collide;
  end

  // Storage: zeroed one entry per cycle while clearing, then normal writes
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (gen_commit) begin
        mem[waddr] <= wdata;
      end
      if (link_en) begin
        mem[LINK_IDX] <= link_val;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;

      assign addr = rd_addr[g*ADDR_W +: ADDR_W];

      // Read mux: zero register, link bypass, general bypass, then storage
      always_comb begin
        val = '0;
        if (!ready || addr == '0) begin
          val = '0;
        end else if (link_en && addr == LINK_IDX) begin
          val = link_val;
        end else if (gen_commit && addr == waddr) begin
          val = wdata;
        end else begin
          val = mem[addr];
        end
      end

      assign rd_data[g*DATA_W +: DATA_W] = val;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic        clk;
  int          n_checks;
  int          n_fail;

  // Default configuration instance
  logic        rst_a;
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic        we_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic        link_we_a;
  logic [31:0] link_pc_a;
  logic        init_busy_a;
  logic        wr_collision_a;

  // Narrow, four-port instance
  logic        rst_b;
  logic [11:0] rd_addr_b;
  logic [63:0] rd_data_b;
  logic        we_b;
  logic [2:0]  waddr_b;
  logic [15:0] wdata_b;
  logic        link_we_b;
  logic [15:0] link_pc_b;
  logic        init_busy_b;
  logic        wr_collision_b;

  regfile_mp u_dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .rd_addr      (rd_addr_a),
    .rd_data      (rd_data_a),
    .we           (we_a),
    .waddr        (waddr_a),
    .wdata        (wdata_a),
    .link_we      (link_we_a),
    .link_pc      (link_pc_a),
    .init_busy    (init_busy_a),
    .wr_collision (wr_collision_a)
  );

  regfile_mp #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .NUM_RD   (4),
    .LINK_REG (7)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .rd_addr      (rd_addr_b),
    .rd_data      (rd_data_b),
    .we           (we_b),
    .waddr        (waddr_b),
    .wdata        (wdata_b),
    .link_we      (link_we_b),
    .link_pc      (link_pc_b),
    .init_busy    (init_busy_b),
    .wr_collision (wr_collision_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy_a(output int n);
    n = 0;
    while (init_busy_a && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    while (init_busy_b && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [15:0] exp_b [8];
    exp_b[0] = 16'h0000;
    exp_b[1] = 16'h1111;
    exp_b[2] = 16'h1222;
    exp_b[3] = 16'h1333;
    exp_b[4] = 16'h1444;
    exp_b[5] = 16'h1555;
    exp_b[6] = 16'h1666;
    exp_b[7] = 16'h1777;

    n_checks  = 0;
    n_fail    = 0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    rd_addr_a = '0;
    we_a      = 1'b0;
    waddr_a   = '0;
    wdata_a   = '0;
    link_we_a = 1'b0;
    link_pc_a = '0;
    rd_addr_b = '0;
    we_b      = 1'b0;
    waddr_b   = '0;
    wdata_b   = '0;
    link_we_b = 1'b0;
    link_pc_b = '0;
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;

    // Reset state and full clear length
    check("reset_busy", 32'(init_busy_a), 32'd1);
    check("reset_coll", 32'(wr_collision_a), 32'd0);
    repeat (3) tick();
    rst_a = 1'b1;
    rd_addr_a = {5'd31, 5'd5};
    #1;
    check("busy_rd0_zero", rd_data_a[31:0], 32'h0);
    check("busy_rd1_zero", rd_data_a[63:32], 32'h0);
    count_busy_a(n);
    check("clear_len", 32'(n), 32'd31);

    // General write with same-cycle bypass, then from storage
    rd_addr_a = {5'd6, 5'd5};
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF;
    #1;
    check("wr_bypass", rd_data_a[31:0], 32'hDEADBEEF);
    check("unrelated_reg", rd_data_a[63:32], 32'h0);
    tick();
    we_a = 1'b0;
    #1;
    check("wr_stored", rd_data_a[31:0], 32'hDEADBEEF);
    rd_addr_a = {5'd6, 5'd0};
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h12345678;
    #1;
    check("r0_bypass", rd_data_a[31:0], 32'h0);
    tick();
    we_a = 1'b0;
    #1;
    check("r0_stored", rd_data_a[31:0], 32'h0);

    // Link writes including wrap-around
    rd_addr_a = {5'd31, 5'd5};
    link_we_a = 1'b1; link_pc_a = 32'hBFC00010;
    #1;
    check("link_bypass", rd_data_a[63:32], 32'hBFC00018);
    tick();
    link_we_a = 1'b0;
    #1;
    check("link_stored", rd_data_a[63:32], 32'hBFC00018);
    link_we_a = 1'b1; link_pc_a = 32'hFFFFFFFC;
    #1;
    check("link_wrap_byp", rd_data_a[63:32], 32'h00000004);
    tick();
    link_we_a = 1'b0;
    #1;
    check("link_wrap", rd_data_a[63:32], 32'h00000004);

    // Collision: link wins, one-cycle pulse
    we_a = 1'b1; waddr_a = 5'd31; wdata_a = 32'h11111111;
    link_we_a = 1'b1; link_pc_a = 32'h00400000;
    #1;
    check("coll_bypass", rd_data_a[63:32], 32'h00400008);
    check("coll_pre", 32'(wr_collision_a), 32'd0);
    tick();
    we_a = 1'b0; link_we_a = 1'b0;
    #1;
    check("coll_pulse", 32'(wr_collision_a), 32'd1);
    check("coll_stored", rd_data_a[63:32], 32'h00400008);
    tick();
    check("coll_drop", 32'(wr_collision_a), 32'd0);

    // Back-to-back collisions keep the flag high
    we_a = 1'b1; waddr_a = 5'd31; wdata_a = 32'h22222222;
    link_we_a = 1'b1; link_pc_a = 32'h00000100;
    tick();
    check("coll_rep1", 32'(wr_collision_a), 32'd1);
    tick();
    we_a = 1'b0; link_we_a = 1'b0;
    #1;
    check("coll_rep2", 32'(wr_collision_a), 32'd1);
    tick();
    check("coll_rep_end", 32'(wr_collision_a), 32'd0);

    // Both ports to different registers commit together
    rd_addr_a = {5'd31, 5'd7};
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h00000077;
    link_we_a = 1'b1; link_pc_a = 32'h00000100;
    #1;
    check("dual_byp_gen", rd_data_a[31:0], 32'h00000077);
    check("dual_byp_link", rd_data_a[63:32], 32'h00000108);
    tick();
    we_a = 1'b0; link_we_a = 1'b0;
    #1;
    check("dual_no_coll", 32'(wr_collision_a), 32'd0);
    check("dual_gen", rd_data_a[31:0], 32'h00000077);
    check("dual_link", rd_data_a[63:32], 32'h00000108);

    // General write alone to the link register commits normally
    we_a = 1'b1; waddr_a = 5'd31; wdata_a = 32'hCAFEF00D;
    tick();
    we_a = 1'b0;
    #1;
    check("gen_to_link", rd_data_a[63:32], 32'hCAFEF00D);
    check("gen_to_link_nc", 32'(wr_collision_a), 32'd0);

    // Writes ignored during clear; reset mid-clear restarts the sequence
    rst_a = 1'b0;
    #1;
    check("rst2_busy", 32'(init_busy_a), 32'd1);
    tick();
    rst_a = 1'b1;
    rd_addr_a = {5'd31, 5'd5};
    we_a = 1'b1; waddr_a = 5'd31; wdata_a = 32'h5;
    link_we_a = 1'b1; link_pc_a = 32'h10;
    #1;
    check("clr_rd0_zero", rd_data_a[31:0], 32'h0);
    check("clr_rd1_zero", rd_data_a[63:32], 32'h0);
    repeat (10) tick();
    check("clr_no_coll", 32'(wr_collision_a), 32'd0);
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    waddr_a = 5'd3;
    count_busy_a(n);
    check("restart_len", 32'(n), 32'd31);
    we_a = 1'b0; link_we_a = 1'b0;
    rd_addr_a = {5'd31, 5'd3};
    #1;
    check("clr_reg3", rd_data_a[31:0], 32'h0);
    check("clr_reg31", rd_data_a[63:32], 32'h0);
    rd_addr_a = {5'd7, 5'd5};
    #1;
    check("clr_reg5", rd_data_a[31:0], 32'h0);
    check("clr_reg7", rd_data_a[63:32], 32'h0);

    // Narrow four-port configuration
    rst_b = 1'b1;
    #1;
    count_busy_b(n);
    check("b_clear_len", 32'(n), 32'd7);
    for (int i = 1; i < 8; i++) begin
      we_b = 1'b1; waddr_b = 3'(i); wdata_b = exp_b[i];
      tick();
    end
    we_b = 1'b0;
    rd_addr_b = {3'd7, 3'd5, 3'd3, 3'd1};
    #1;
    check("b_p0_r1", 32'(rd_data_b[15:0]), 32'(exp_b[1]));
    check("b_p1_r3", 32'(rd_data_b[31:16]), 32'(exp_b[3]));
    check("b_p2_r5", 32'(rd_data_b[47:32]), 32'(exp_b[5]));
    check("b_p3_r7", 32'(rd_data_b[63:48]), 32'(exp_b[7]));
    rd_addr_b = {3'd2, 3'd4, 3'd6, 3'd0};
    #1;
    check("b_p0_r0", 32'(rd_data_b[15:0]), 32'(exp_b[0]));
    check("b_p1_r6", 32'(rd_data_b[31:16]), 32'(exp_b[6]));
    check("b_p2_r4", 32'(rd_data_b[47:32]), 32'(exp_b[4]));
    check("b_p3_r2", 32'(rd_data_b[63:48]), 32'(exp_b[2]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port general-purpose register file for the MIPS core pipeline. Successor to the 2-read/1-write register file, adding:
- configurable width, depth and read-port count
- a dedicated link-register write port for jal/jalr
- write-to-read bypass on both write ports
- a hardware clear sequencer after reset
- registered collision reporting

Sits between decode (read) and write-back (write). Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of combinational read ports (1..4)
LINK_REG, 31, register index written by the link port
LINK_OFFSET, 8, byte offset added to link_pc (delay-slot return address)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
we  in  1  general write enable (write-back stage)
waddr  in  ADDR_W  general write address
wdata  in  DATA_W  general write data
link_we  in  1  link write enable (jal/jalr)
link_pc  in  DATA_W  address of the linking instruction
init_busy  out  1  high while reset is asserted or the clear sequencer runs; pipeline stalls on it
wr_collision  out  1  registered one-cycle pulse; general write dropped in favour of link write

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to CLEAR, clear counter to 1.
  - init_busy=1, wr_collision=0.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: each cycle write 0 to reg[counter], counter+1. When counter==DEPTH-1 is cleared, go to READY on the next edge. Duration is DEPTH-1 cycles after rst rises (31 cycles at default).
  - READY: init_busy=0; normal operation. Stays in READY until the next reset.
- Reset asserted mid-CLEAR: counter returns to 1; the sequence restarts from the beginning.
- While init_busy=1:
  - we and link_we are ignored (no array update, no collision pulse).
  - All rd_data read 0.
- Reads (READY): combinational, zero latency. Per port i, priority:
  1. addr==0 -> 0
  2. link_we && addr==LINK_REG -> link value
  3. we && addr==waddr && waddr!=0 && !(link_we && waddr==LINK_REG) -> wdata
  4. otherwise reg[addr]
- Link value = link_pc + LINK_OFFSET, truncated to DATA_W; wrap-around modulo 2**DATA_W is legal.
- Writes (READY, rising edge):
  - we with waddr==0: no effect.
  - we and link_we targeting different registers: both commit in the same edge.
  - we && link_we && waddr==LINK_REG: link value commits, wdata is dropped, wr_collision=1 for exactly the following cycle.
  - we alone with waddr==LINK_REG: wdata commits normally.
- wr_collision: registered; deasserts the cycle after the pulse unless a collision repeats, in which case it stays high.
- Width rule: no sign or zero extension; all data paths are exactly DATA_W.

Test Plan:
1. Hold rst=0 for 3 cycles, release -> init_busy=1 for exactly 31 cycles, then 0; every rd_addr reads 0x00000000. Pulse rst low at cycle 10 of CLEAR -> a full 31-cycle CLEAR restarts.
2. READY, we=1, waddr=5, wdata=0xDEADBEEF, rd_addr0=5 same cycle -> rd_data0=0xDEADBEEF combinationally. Next cycle with we=0 -> still 0xDEADBEEF. Repeat with waddr=0 -> reg 0 reads 0.
3. link_we=1, link_pc=0xBFC00010, rd_addr1=31 -> rd_data1=0xBFC00018 same cycle and after the edge. Then link_pc=0xFFFFFFFC -> reg31=0x00000004 (wrap).
4. Same edge: we=1, waddr=31, wdata=0x11111111, link_we=1, link_pc=0x00400000 -> reg31=0x00400008, wr_collision=1 for one cycle only. Same edge: we to reg 7 plus link_we -> both commit, wr_collision=0.
5. During CLEAR: we=1, waddr=3, wdata=0x5 -> ignored; after READY, reg3 reads 0.
6. NUM_RD=4, DATA_W=16, ADDR_W=3: write reg1..reg7 distinct values; read all four ports with different addresses simultaneously -> each returns its value; CLEAR lasts 7 cycles.
